demux_1xn_stream: RTL and testbench
===================================

DEMUX_1XN_STREAM -- requirements
Module: demux_1xn_stream

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, meaning payload width in bits (1..64).
REQ-002 SHALL provide parameter N_CH, default 4, meaning number of output channels (2..16).
REQ-003 SHALL derive localparam SEL_W = max(1, ceil(log2(N_CH))), meaning select width.
REQ-004 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL provide port rst_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL provide port in_data  input  DATA_W  payload to route.
REQ-007 SHALL provide port in_sel  input  SEL_W  target channel; used only when rr_mode=0.
REQ-008 SHALL provide port rr_mode  input  1  0 = routing by in_sel, 1 = round-robin routing.
REQ-009 SHALL provide port in_valid  input  1  payload and select valid.
REQ-010 SHALL provide port in_ready  output  1  block can accept this cycle.
REQ-011 SHALL provide port out_data  output  N_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
REQ-012 SHALL provide port out_valid  output  N_CH  per-channel valid.
REQ-013 SHALL provide port out_ready  input  N_CH  per-channel downstream ready.
REQ-014 SHALL provide port sel_err  output  1  one-cycle pulse: out-of-range select was consumed.

Function
REQ-015 SHALL hold one registered entry per channel (data + valid); out_data/out_valid driven directly from these registers.
REQ-016 SHALL compute target = rr_ptr when rr_mode=1, else in_sel.
REQ-017 SHALL assert in_ready when target < N_CH and (channel target empty, or out_valid[target] and out_ready[target] both 1 this cycle).
REQ-018 SHALL assert in_ready unconditionally when rr_mode=0 and in_sel >= N_CH (discard path).
REQ-019 SHALL define accept = in_valid and in_ready; in_ready SHALL not depend combinationally on in_valid.
REQ-020 SHALL, on accept to a valid target, load in_data into that channel and set its out_valid at the next edge (latency 1 cycle).
REQ-021 SHALL clear out_valid[k] at the edge where out_valid[k] and out_ready[k] are 1, unless a new accept loads channel k on the same edge (valid stays 1, data replaced).
REQ-022 SHALL keep out_data[k] stable while out_valid[k]=1 and out_ready[k]=0.
REQ-023 SHALL, on accept with in_sel >= N_CH, drop the payload, modify no channel, and pulse sel_err high for exactly the following cycle.
REQ-024 SHALL advance rr_ptr only on accept with rr_mode=1, incrementing by 1 and wrapping N_CH-1 -> 0.
REQ-025 SHALL retain rr_ptr across rr_mode changes; mode change takes effect the same cycle.
REQ-026 SHALL, in round-robin mode with target channel full and not draining, hold in_ready=0 (no skip to other channels).
REQ-027 SHALL drain channels independently; out_ready on one channel SHALL not affect others.
REQ-028 SHALL sustain one transfer per cycle when target channel drains each cycle.

Reset
REQ-029 SHALL, while rst_n=0 at a rising edge, clear all out_valid to 0, all out_data to 0, rr_ptr to 0, sel_err to 0.
REQ-030 SHALL discard any held entries and any accept coincident with reset; in_ready SHALL be 0 while rst_n=0.
REQ-031 SHALL resume normal operation on the first edge with rst_n=1.

Verification
REQ-032 Reset: rst_n=0 two cycles with in_valid=1 -> out_valid=0, out_data=0, in_ready=0, sel_err=0.
REQ-033 Select mode, N_CH=4, out_ready=0: send 0xA5 sel=2 -> next cycle out_valid=4'b0100, ch2 data 0xA5; second send sel=2 -> in_ready=0 until out_ready[2]=1.
REQ-034 Round-robin, all out_ready=1: send 0x10..0x15 on consecutive cycles -> ch0,1,2,3,0,1 receive 0x10..0x15, one per cycle, rr_ptr ends at 2.
REQ-035 Back-to-back same channel: sel=1, out_ready[1]=1, send 0x01,0x02,0x03 consecutively -> out_valid[1] stays 1 three cycles, data 0x01,0x02,0x03, no stall.
REQ-036 N_CH=3, select mode: send sel=3 data 0xFF -> in_ready=1, sel_err=1 next cycle only, no out_valid change.
REQ-037 Reset mid-operation: channels 0 and 3 full, rr_ptr=2, assert rst_n=0 one cycle -> all out_valid=0, rr_ptr=0; next round-robin send lands in ch0.

Source files
------------

// File: rtl/demux_1xn_stream.sv
// demux_1xn_stream: routes a single valid/ready input stream to one of N_CH
// registered output channels. The target is picked by in_sel or by an
// internal round-robin pointer. An out-of-range select is consumed and
// dropped, and sel_err is pulsed for one cycle to report the drop.
module demux_1xn_stream #(
  parameter  int DATA_W = 8,
  parameter  int N_CH   = 4,
  localparam int SEL_W  = (N_CH > 2) ? $clog2(N_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   rr_mode,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [N_CH*DATA_W-1:0] out_data,
  output logic [N_CH-1:0]        out_valid,
  input  logic [N_CH-1:0]        out_ready,
  output logic                   sel_err
);

  // One extra bit so that in_sel can be compared against N_CH even when
  // N_CH is a power of two (in that case no select value is out of range).
  localparam logic [SEL_W:0]   N_CH_W  = (SEL_W+1)'(N_CH);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

  logic [SEL_W-1:0] rr_ptr_r;
  logic [SEL_W-1:0] target_s;
  logic             sel_oob_s;
  logic [N_CH-1:0]  hit_s;
  logic [N_CH-1:0]  free_s;
  logic             ready_s;
  logic             accept_s;
  logic             sel_err_r;

  // Target selection, out-of-range detection and per-channel decode.
  always_comb begin
    target_s  = in_sel;
    sel_oob_s = 1'b0;
    if (rr_mode) begin
      target_s  = rr_ptr_r;
      sel_oob_s = 1'b0;
    end else begin
      target_s  = in_sel;
      sel_oob_s = ({1'b0, in_sel} >= N_CH_W);
    end
    for (int k = 0; k < N_CH; k++) begin
      hit_s[k]  = (target_s == SEL_W'(k));
      // A channel can take a new entry if it is empty or is draining now.
      free_s[k] = ~out_valid[k] | out_ready[k];
    end
  end

  // Ready depends only on the target and the channel state, never on
  // in_valid. Ready is forced low while reset is held.
  always_comb begin
    ready_s  = rst_n & (sel_oob_s | (|(hit_s & free_s)));
    accept_s = in_valid & ready_s;
  end

  assign in_ready = ready_s;
  assign sel_err  = sel_err_r;

  // Channel entries: load on accept to that channel, otherwise clear on drain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= '0;
      out_data  <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (accept_s && hit_s[k]) begin
          out_data[k*DATA_W +: DATA_W] <= in_data;
          out_valid[k]                 <= 1'b1;
        end else if (out_ready[k]) begin
          out_valid[k] <= 1'b0;
        end else begin
          out_valid[k] <= out_valid[k];
        end
      end
    end
  end

  // Round-robin pointer advances only on accepts made in round-robin mode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_r <= '0;
    end else if (accept_s && rr_mode) begin
      if (rr_ptr_r == LAST_CH) begin
        rr_ptr_r <= '0;
      end else begin
        rr_ptr_r <= rr_ptr_r + SEL_W'(1);
      end
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // One-cycle error pulse after an out-of-range select is consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_err_r <= 1'b0;
    end else begin
      sel_err_r <= accept_s & sel_oob_s;
    end
  end

endmodule

// File: tb/tb_demux_1xn_stream.sv
// Testbench for demux_1xn_stream: instance a (N_CH=4) and instance b (N_CH=3)
// checked against a slot-level reference model, directed tables and random traffic.
module tb_demux_1xn_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [7:0]  a_data;  logic [1:0] a_sel; logic a_rr, a_valid, a_iready;
  logic [31:0] a_odata; logic [3:0] a_ovalid, a_oready; logic a_err;
  logic [7:0]  b_data;  logic [1:0] b_sel; logic b_rr, b_valid, b_iready;
  logic [23:0] b_odata; logic [2:0] b_ovalid, b_oready; logic b_err;

  demux_1xn_stream #(.DATA_W(8), .N_CH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_sel(a_sel), .rr_mode(a_rr),
    .in_valid(a_valid), .in_ready(a_iready), .out_data(a_odata),
    .out_valid(a_ovalid), .out_ready(a_oready), .sel_err(a_err));

  demux_1xn_stream #(.DATA_W(8), .N_CH(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_sel(b_sel), .rr_mode(b_rr),
    .in_valid(b_valid), .in_ready(b_iready), .out_data(b_odata),
    .out_valid(b_ovalid), .out_ready(b_oready), .sel_err(b_err));

  int total = 0;
  int bad   = 0;

  // Reference model: each channel is a one-entry slot; index 0 = a, 1 = b.
  logic       m_v   [2][4];
  logic [7:0] m_d   [2][4];
  int         m_ptr [2];
  logic       m_err [2];
  logic       last_rdy_a, last_rdy_b;

  typedef struct {
    logic       rr;  logic [1:0] sel; logic vld; logic [7:0] d; logic [3:0] ordy;
    logic       exp_rdy; logic [3:0] exp_ov; int exp_ch; logic [7:0] exp_d;
  } vec_t;
  vec_t tbl [23];

  function automatic vec_t mk(logic rr, logic [1:0] sel, logic vld, logic [7:0] d,
                              logic [3:0] ordy, logic er, logic [3:0] eov, int ech,
                              logic [7:0] ed);
    vec_t v;
    v.rr = rr; v.sel = sel; v.vld = vld; v.d = d; v.ordy = ordy;
    v.exp_rdy = er; v.exp_ov = eov; v.exp_ch = ech; v.exp_d = ed;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_ready(int i, int n, logic rst, logic rr,
                                       logic [1:0] sel, logic [3:0] ordy);
    int t;
    t = rr ? m_ptr[i] : int'(sel);
    if (!rst) return 1'b0;
    if (t >= n) return 1'b1;           // out-of-range select: discard path
    return !m_v[i][t] || ordy[t];
  endfunction

  task automatic model_edge(int i, int n, logic rst, logic rr, logic [1:0] sel,
                            logic vld, logic [7:0] d, logic [3:0] ordy);
    int t; logic acc;
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin m_v[i][k] = 1'b0; m_d[i][k] = 8'h00; end
      m_ptr[i] = 0; m_err[i] = 1'b0;
      return;
    end
    t   = rr ? m_ptr[i] : int'(sel);
    acc = vld && model_ready(i, n, rst, rr, sel, ordy);
    for (int k = 0; k < n; k++) if (m_v[i][k] && ordy[k]) m_v[i][k] = 1'b0;
    m_err[i] = 1'b0;
    if (acc) begin
      if (t >= n) m_err[i] = 1'b1;
      else begin m_v[i][t] = 1'b1; m_d[i][t] = d; end
      if (rr) m_ptr[i] = (m_ptr[i] + 1) % n;
    end
  endtask

  task automatic check_outs(int i, int n, logic [3:0] ov, logic [31:0] od, logic er);
    logic [3:0] ev;
    ev = 4'b0;
    for (int k = 0; k < n; k++) ev[k] = m_v[i][k];
    chk($sformatf("out_valid_%0d", i), 32'(ov), 32'(ev));
    for (int k = 0; k < n; k++)
      if (m_v[i][k]) chk($sformatf("out_data_%0d_ch%0d", i, k), 32'(od[k*8 +: 8]), 32'(m_d[i][k]));
    chk($sformatf("sel_err_%0d", i), 32'(er), 32'(m_err[i]));
  endtask

  // One clock: check ready before the edge, advance model, check outputs after.
  task automatic tick();
    #1;
    last_rdy_a = a_iready;
    last_rdy_b = b_iready;
    chk("in_ready_a", 32'(a_iready), 32'(model_ready(0, 4, rst_n, a_rr, a_sel, a_oready)));
    chk("in_ready_b", 32'(b_iready), 32'(model_ready(1, 3, rst_n, b_rr, b_sel, {1'b0, b_oready})));
    @(posedge clk);
    model_edge(0, 4, rst_n, a_rr, a_sel, a_valid, a_data, a_oready);
    model_edge(1, 3, rst_n, b_rr, b_sel, b_valid, b_data, {1'b0, b_oready});
    #1;
    check_outs(0, 4, a_ovalid, a_odata, a_err);
    check_outs(1, 3, {1'b0, b_ovalid}, {8'h00, b_odata}, b_err);
    @(negedge clk);
  endtask

  task automatic drive_a(logic rr, logic [1:0] sel, logic vld, logic [7:0] d, logic [3:0] ordy);
    a_rr = rr; a_sel = sel; a_valid = vld; a_data = d; a_oready = ordy;
  endtask

  task automatic idle_b();
    b_rr = 1'b0; b_sel = 2'd0; b_valid = 1'b0; b_data = 8'h00; b_oready = 3'b000;
  endtask

  initial begin
    tbl[0]  = mk(1'b0, 2'd2, 1'b1, 8'hA5, 4'b0000, 1'b1, 4'b0100,  2, 8'hA5);
    tbl[1]  = mk(1'b0, 2'd2, 1'b1, 8'h5A, 4'b0000, 1'b0, 4'b0100,  2, 8'hA5);
    tbl[2]  = mk(1'b0, 2'd2, 1'b1, 8'h5A, 4'b0000, 1'b0, 4'b0100,  2, 8'hA5);
    tbl[3]  = mk(1'b0, 2'd2, 1'b1, 8'h5A, 4'b0100, 1'b1, 4'b0100,  2, 8'h5A);
    tbl[4]  = mk(1'b0, 2'd2, 1'b0, 8'h00, 4'b0100, 1'b1, 4'b0000, -1, 8'h00);
    tbl[5]  = mk(1'b1, 2'd0, 1'b1, 8'h10, 4'b1111, 1'b1, 4'b0001,  0, 8'h10);
    tbl[6]  = mk(1'b1, 2'd0, 1'b1, 8'h11, 4'b1111, 1'b1, 4'b0010,  1, 8'h11);
    tbl[7]  = mk(1'b1, 2'd0, 1'b1, 8'h12, 4'b1111, 1'b1, 4'b0100,  2, 8'h12);
    tbl[8]  = mk(1'b1, 2'd0, 1'b1, 8'h13, 4'b1111, 1'b1, 4'b1000,  3, 8'h13);
    tbl[9]  = mk(1'b1, 2'd0, 1'b1, 8'h14, 4'b1111, 1'b1, 4'b0001,  0, 8'h14);
    tbl[10] = mk(1'b1, 2'd0, 1'b1, 8'h15, 4'b1111, 1'b1, 4'b0010,  1, 8'h15);
    tbl[11] = mk(1'b1, 2'd0, 1'b0, 8'h00, 4'b1111, 1'b1, 4'b0000, -1, 8'h00);
    tbl[12] = mk(1'b0, 2'd1, 1'b1, 8'h01, 4'b0010, 1'b1, 4'b0010,  1, 8'h01);
    tbl[13] = mk(1'b0, 2'd1, 1'b1, 8'h02, 4'b0010, 1'b1, 4'b0010,  1, 8'h02);
    tbl[14] = mk(1'b0, 2'd1, 1'b1, 8'h03, 4'b0010, 1'b1, 4'b0010,  1, 8'h03);
    tbl[15] = mk(1'b0, 2'd1, 1'b0, 8'h00, 4'b0010, 1'b1, 4'b0000, -1, 8'h00);
    tbl[16] = mk(1'b1, 2'd0, 1'b1, 8'h77, 4'b0000, 1'b1, 4'b0100,  2, 8'h77);
    tbl[17] = mk(1'b1, 2'd0, 1'b1, 8'h88, 4'b0000, 1'b1, 4'b1100,  3, 8'h88);
    tbl[18] = mk(1'b1, 2'd0, 1'b1, 8'h99, 4'b0000, 1'b1, 4'b1101,  0, 8'h99);
    tbl[19] = mk(1'b1, 2'd0, 1'b1, 8'hAA, 4'b0000, 1'b1, 4'b1111,  1, 8'hAA);
    tbl[20] = mk(1'b1, 2'd0, 1'b1, 8'hBB, 4'b0000, 1'b0, 4'b1111,  2, 8'h77);
    tbl[21] = mk(1'b0, 2'd3, 1'b1, 8'hCC, 4'b0000, 1'b0, 4'b1111,  3, 8'h88);
    tbl[22] = mk(1'b1, 2'd0, 1'b1, 8'hBB, 4'b0100, 1'b1, 4'b1111,  2, 8'hBB);

    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 4; k++) begin m_v[i][k] = 1'b0; m_d[i][k] = 8'h00; end
      m_ptr[i] = 0; m_err[i] = 1'b0;
    end

    // Reset held two cycles with valid input on both instances.
    @(negedge clk);
    rst_n = 1'b0;
    drive_a(1'b0, 2'd1, 1'b1, 8'h3C, 4'b0000);
    b_rr = 1'b0; b_sel = 2'd3; b_valid = 1'b1; b_data = 8'hC3; b_oready = 3'b000;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_ready_a", 32'(last_rdy_a), 32'd0);
      chk("rst_ready_b", 32'(last_rdy_b), 32'd0);
      chk("rst_ovalid_a", 32'(a_ovalid), 32'd0);
      chk("rst_odata_a", a_odata, 32'd0);
      chk("rst_odata_b", 32'(b_odata), 32'd0);
      chk("rst_err", 32'({a_err, b_err}), 32'd0);
    end
    rst_n = 1'b1;
    idle_b();

    // Directed table on instance a.
    for (int i = 0; i < 23; i++) begin
      drive_a(tbl[i].rr, tbl[i].sel, tbl[i].vld, tbl[i].d, tbl[i].ordy);
      tick();
      chk($sformatf("tbl%0d_ready", i), 32'(last_rdy_a), 32'(tbl[i].exp_rdy));
      chk($sformatf("tbl%0d_ovalid", i), 32'(a_ovalid), 32'(tbl[i].exp_ov));
      if (tbl[i].exp_ch >= 0)
        chk($sformatf("tbl%0d_data", i), 32'(a_odata[tbl[i].exp_ch*8 +: 8]), 32'(tbl[i].exp_d));
    end

    // Reset mid-operation with ch0 and ch3 full and pointer at 2.
    rst_n = 1'b0; drive_a(1'b0, 2'd0, 1'b0, 8'h00, 4'b0000); tick();
    rst_n = 1'b1;
    drive_a(1'b1, 2'd0, 1'b1, 8'h01, 4'b0000);
    b_rr = 1'b0; b_sel = 2'd3; b_valid = 1'b1; b_data = 8'hFF; b_oready = 3'b000;
    tick();
    chk("oob_ready_b", 32'(last_rdy_b), 32'd1);
    chk("oob_err_b", 32'(b_err), 32'd1);
    chk("oob_ovalid_b", 32'(b_ovalid), 32'd0);
    idle_b();
    drive_a(1'b1, 2'd0, 1'b1, 8'h02, 4'b0000); tick();
    chk("oob_err_b_clear", 32'(b_err), 32'd0);
    chk("oob_ovalid_b_after", 32'(b_ovalid), 32'd0);
    drive_a(1'b0, 2'd3, 1'b1, 8'h33, 4'b0010); tick();
    chk("mid_ovalid", 32'(a_ovalid), 32'b1001);
    rst_n = 1'b0; drive_a(1'b1, 2'd0, 1'b1, 8'hDD, 4'b0000); tick();
    chk("mid_rst_ready", 32'(last_rdy_a), 32'd0);
    chk("mid_rst_ovalid", 32'(a_ovalid), 32'd0);
    chk("mid_rst_odata", a_odata, 32'd0);
    rst_n = 1'b1; drive_a(1'b1, 2'd0, 1'b1, 8'hEE, 4'b0000); tick();
    chk("post_rst_ovalid", 32'(a_ovalid), 32'b0001);
    chk("post_rst_data", 32'(a_odata[7:0]), 32'hEE);

    // Random traffic on both instances, checked against the model.
    for (int c = 0; c < 3000; c++) begin
      rst_n    = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 7) == 0) a_rr = ~a_rr;
      if ($urandom_range(0, 7) == 0) b_rr = ~b_rr;
      a_sel    = 2'($urandom_range(0, 3));
      b_sel    = 2'($urandom_range(0, 3));
      a_valid  = ($urandom_range(0, 3) != 0);
      b_valid  = ($urandom_range(0, 3) != 0);
      a_data   = 8'($urandom);
      b_data   = 8'($urandom);
      a_oready = 4'($urandom);
      b_oready = 3'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
